// File: rtl/imm_pkg.sv
// Shared types, opcode constants and helpers for the immediate decode stage.
// Used by both the combinational decoder and the registered stage wrapper.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_J    = 3'd3,
      IMM_U    = 3'd4,
      IMM_Z    = 3'd5,
      IMM_SH   = 3'd6,
      IMM_NONE = 3'd7
   } imm_type_t;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   // Widens a 32-bit immediate that is already sign-correct at bit 31.
   function automatic logic [63:0] sign_ext(input logic [31:0] val);
      return {{32{val[31]}}, val};
   endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Purely combinational immediate type decode and extension to XLEN bits.
// Illegal opcodes decode to type NONE, which always produces a zero immediate.
module imm_decode_comb
   import imm_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   input  logic            force_en,
   input  logic [2:0]      force_type,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      imm_type,
   output logic            illegal
);

   localparam bit IS_RV64 = (XLEN == 64);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       shift_like;
   logic       wide_shamt;
   logic       auto_illegal;
   imm_type_t  auto_type;
   imm_type_t  sel_type;
   logic [31:0] raw;

   assign opcode     = instr[6:0];
   assign funct3     = instr[14:12];
   assign shift_like = (funct3 == 3'b001) || (funct3 == 3'b101);
   // Only the native-width OP-IMM shift gets the 6-bit shamt; the W form stays 5-bit.
   assign wide_shamt = IS_RV64 && (opcode == OPC_OP_IMM);

   always_comb begin
      auto_type    = IMM_NONE;
      auto_illegal = 1'b0;
      case (opcode)
         OPC_OP_IMM:    auto_type = shift_like ? IMM_SH : IMM_I;
         OPC_OP_IMM_32: begin
            if (IS_RV64) auto_type    = shift_like ? IMM_SH : IMM_I;
            else         auto_illegal = 1'b1;
         end
         OPC_LOAD, OPC_JALR, OPC_MISC_MEM: auto_type = IMM_I;
         OPC_STORE:            auto_type = IMM_S;
         OPC_BRANCH:           auto_type = IMM_B;
         OPC_JAL:              auto_type = IMM_J;
         OPC_LUI, OPC_AUIPC:   auto_type = IMM_U;
         OPC_SYSTEM:           auto_type = funct3[2] ? IMM_Z : IMM_I;
         OPC_OP:               auto_type = IMM_NONE;
         OPC_OP_32:            auto_illegal = !IS_RV64;
         default:              auto_illegal = 1'b1;
      endcase
   end

   assign sel_type = force_en ? imm_type_t'(force_type) : auto_type;
   assign imm_type = sel_type;
   assign illegal  = !force_en && auto_illegal;

   always_comb begin
      raw = 32'd0;
      case (sel_type)
         IMM_I:  raw = {{20{instr[31]}}, instr[31:20]};
         IMM_S:  raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:  raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:  raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         IMM_U:  raw = {instr[31:12], 12'd0};
         IMM_Z:  raw = {27'd0, instr[19:15]};
         IMM_SH: raw = wide_shamt ? {26'd0, instr[25:20]} : {27'd0, instr[24:20]};
         default: raw = 32'd0;
      endcase
   end

   if (XLEN == 64) begin : g_rv64
      assign imm = sign_ext(raw);
   end else begin : g_rv32
      assign imm = raw;
   end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decode stage: decoder, main register plus one skid entry,
// and a saturating counter of illegal instructions accepted at the input.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN      = 64,
   parameter int TAG_WIDTH = 64,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [TAG_WIDTH-1:0] in_tag,
   input  logic                 force_en,
   input  logic [2:0]           force_type,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_imm,
   output logic [2:0]           out_type,
   output logic                 out_illegal,
   output logic [TAG_WIDTH-1:0] out_tag,
   output logic [CNT_WIDTH-1:0] illegal_cnt,
   input  logic                 cnt_clear
);

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_type;
   logic            dec_illegal;

   imm_decode_comb #(.XLEN(XLEN)) u_decode (
      .instr      (in_instr),
      .force_en   (force_en),
      .force_type (force_type),
      .imm        (dec_imm),
      .imm_type   (dec_type),
      .illegal    (dec_illegal)
   );

   logic                 main_valid_q,   main_valid_d;
   logic [XLEN-1:0]      main_imm_q,     main_imm_d;
   logic [2:0]           main_type_q,    main_type_d;
   logic                 main_illegal_q, main_illegal_d;
   logic [TAG_WIDTH-1:0] main_tag_q,     main_tag_d;
   logic                 skid_valid_q,   skid_valid_d;
   logic [XLEN-1:0]      skid_imm_q,     skid_imm_d;
   logic [2:0]           skid_type_q,    skid_type_d;
   logic                 skid_illegal_q, skid_illegal_d;
   logic [TAG_WIDTH-1:0] skid_tag_q,     skid_tag_d;
   logic [CNT_WIDTH-1:0] cnt_q,          cnt_d;

   logic push;
   logic pop;

   assign in_ready = !skid_valid_q;
   assign push     = in_valid && in_ready;
   assign pop      = main_valid_q && out_ready;

   always_comb begin
      main_valid_d   = main_valid_q;
      main_imm_d     = main_imm_q;
      main_type_d    = main_type_q;
      main_illegal_d = main_illegal_q;
      main_tag_d     = main_tag_q;
      skid_valid_d   = skid_valid_q;
      skid_imm_d     = skid_imm_q;
      skid_type_d    = skid_type_q;
      skid_illegal_d = skid_illegal_q;
      skid_tag_d     = skid_tag_q;
      cnt_d          = cnt_q;

      // The skid is only ever occupied behind a full main register, so it drains first.
      if (!main_valid_q || pop) begin
         if (skid_valid_q) begin
            main_valid_d   = 1'b1;
            main_imm_d     = skid_imm_q;
            main_type_d    = skid_type_q;
            main_illegal_d = skid_illegal_q;
            main_tag_d     = skid_tag_q;
            skid_valid_d   = 1'b0;
         end else begin
            main_valid_d = push;
            if (push) begin
               main_imm_d     = dec_imm;
               main_type_d    = dec_type;
               main_illegal_d = dec_illegal;
               main_tag_d     = in_tag;
            end
         end
      end else if (push) begin
         skid_valid_d   = 1'b1;
         skid_imm_d     = dec_imm;
         skid_type_d    = dec_type;
         skid_illegal_d = dec_illegal;
         skid_tag_d     = in_tag;
      end

      if (cnt_clear) begin
         cnt_d = '0;
      end else if (push && dec_illegal && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // NOTE: payload registers are reset too, because out_* must read zero straight out of reset.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         main_valid_q   <= 1'b0;
         main_imm_q     <= '0;
         main_type_q    <= '0;
         main_illegal_q <= 1'b0;
         main_tag_q     <= '0;
         skid_valid_q   <= 1'b0;
         skid_imm_q     <= '0;
         skid_type_q    <= '0;
         skid_illegal_q <= 1'b0;
         skid_tag_q     <= '0;
         cnt_q          <= '0;
      end else begin
         main_valid_q   <= main_valid_d;
         main_imm_q     <= main_imm_d;
         main_type_q    <= main_type_d;
         main_illegal_q <= main_illegal_d;
         main_tag_q     <= main_tag_d;
         skid_valid_q   <= skid_valid_d;
         skid_imm_q     <= skid_imm_d;
         skid_type_q    <= skid_type_d;
         skid_illegal_q <= skid_illegal_d;
         skid_tag_q     <= skid_tag_d;
         cnt_q          <= cnt_d;
      end
   end

   assign out_valid   = main_valid_q;
   assign out_imm     = main_imm_q;
   assign out_type    = main_type_q;
   assign out_illegal = main_illegal_q;
   assign out_tag     = main_tag_q;
   assign illegal_cnt = cnt_q;

endmodule
